memaccess: RTL and testbench

MEMACCESS -- requirements
Module: memaccess

---
 rtl/lc3_pkg.sv | 26 ++
 rtl/memaccess_timer.sv | 38 +++
 rtl/memaccess.sv | 134 +++++++++++++
 tb/tb_memaccess.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// lc3_pkg: op encodings and access-sequencer states shared by the LC-3 memory path.
package lc3_pkg;

    typedef enum logic [1:0] {
        OP_LD  = 2'd0,
        OP_ST  = 2'd1,
        OP_LDI = 2'd2,
        OP_STI = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_IND  = 2'd1,
        S_ACC  = 2'd2,
        S_RESP = 2'd3
    } state_e;

    function automatic logic op_is_store(input op_e o);
        return (o == OP_ST) || (o == OP_STI);
    endfunction

    function automatic logic op_is_indirect(input op_e o);
        return (o == OP_LDI) || (o == OP_STI);
    endfunction

endpackage

// File: rtl/memaccess_timer.sv
// memaccess_timer: counts stalled memory-request cycles and flags the cycle in
// which the access must be abandoned (TIMEOUT_CYCLES-th consecutive wait cycle).
module memaccess_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] count_q, count_d;

    assign expired = count_en && (count_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        // NOTE: default assignment first so no path leaves count_d unassigned (no latch).
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_en && !expired) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/memaccess.sv
// memaccess: LC-3 LD/ST/LDI/STI sequencer driving a req/ack memory port.
// Optional stalled-memory abort is enabled by defining MEMACCESS_TIMEOUT_EN.
module memaccess
    import lc3_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [15:0] memout,
    output logic        enable_writeback,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        timeout_err
);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] ptr_q, ptr_d;
    logic [15:0] memout_q, memout_d;
    logic        terr_q, terr_d;
    logic        req;
    logic        timeout;

    assign req = (state_q == S_IND) || (state_q == S_ACC);

`ifdef MEMACCESS_TIMEOUT_EN
    logic timer_clear;

    // Restart the wait count on every entry into IND or ACC.
    assign timer_clear = ((state_q == S_IDLE) && start) || ((state_q == S_IND) && mem_ack);

    memaccess_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (timer_clear),
        .count_en (req && !mem_ack),
        .expired  (timeout)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ptr_d    = ptr_q;
        memout_d = memout_q;
        terr_d   = terr_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op_e'(op);
                    addr_d  = addr;
                    wdata_d = wdata;
                    terr_d  = 1'b0;
                    state_d = op_is_indirect(op_e'(op)) ? S_IND : S_ACC;
                end
            end
            S_IND: begin
                if (mem_ack) begin
                    ptr_d   = mem_rdata;
                    state_d = S_ACC;
                end else if (timeout) begin
                    terr_d  = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_ACC: begin
                if (mem_ack) begin
                    if (!op_is_store(op_q)) begin
                        memout_d = mem_rdata;
                    end
                    state_d = S_RESP;
                end else if (timeout) begin
                    terr_d  = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_LD;
            addr_q   <= '0;
            wdata_q  <= '0;
            ptr_q    <= '0;
            memout_q <= '0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ptr_q    <= ptr_d;
            memout_q <= memout_d;
            terr_q   <= terr_d;
        end
    end

    // An aborted access still completes with done, but never writes back.
    assign busy             = (state_q != S_IDLE);
    assign done             = (state_q == S_RESP);
    assign enable_writeback = done && !op_is_store(op_q) && !terr_q;
    assign mem_req          = req;
    assign mem_we           = (state_q == S_ACC) && op_is_store(op_q);
    assign mem_addr         = ((state_q == S_ACC) && op_is_indirect(op_q)) ? ptr_q : addr_q;
    assign mem_wdata        = wdata_q;
    assign memout           = memout_q;
    assign timeout_err      = terr_q;

endmodule

// File: tb/tb_memaccess.sv
// tb_memaccess: directed + randomized bench for memaccess; a transaction-level
// model schedules each access window and the memory responder plays from it.
module tb_memaccess;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        busy;
    logic        done;
    logic [15:0] memout;
    logic        enable_writeback;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        timeout_err;

    memaccess #(.TIMEOUT_CYCLES(TO)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .op               (op),
        .addr             (addr),
        .wdata            (wdata),
        .busy             (busy),
        .done             (done),
        .memout           (memout),
        .enable_writeback (enable_writeback),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .mem_ack          (mem_ack),
        .timeout_err      (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          s;
        int          e;
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        logic [15:0] rdata;
        bit          ack;
    } acc_t;

    acc_t        acc [2];
    int          n_acc = 0;
    int          t_c = 0;
    int          t_r = -1;
    bit          t_active = 0;
    bit          t_load = 0;
    bit          t_abort = 0;
    logic [15:0] model_mem [int];
    logic [15:0] exp_memout = '0;
    bit          exp_terr = 0;

    int total = 0;
    int bad = 0;
    int n_accepts = 0;
    int n_dones = 0;
    bit force_w = 0;
    int fw0 = 0;
    int fw1 = 0;

    int          last_c = 0;
    int          last_done = 0;
    bit          done_seen = 0;
    bit          wb_seen = 0;
    bit          terr_at_done = 0;
    int          req_cycles = 0;
    logic [15:0] first_req_addr = '0;
    logic        first_req_we = 1'b0;
    logic [15:0] wr_addr = '0;
    logic [15:0] wr_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        if (!model_mem.exists(int'(a))) model_mem[int'(a)] = 16'($urandom_range(0, 31));
        return model_mem[int'(a)];
    endfunction

    // One memory access: w wait cycles then ack; w < 0 means the memory never answers.
    task automatic add_acc(input int s, input logic [15:0] a, input logic we,
                           input logic [15:0] wd, input int w);
        acc[n_acc].s     = s;
        acc[n_acc].e     = s + ((w < 0) ? TO : w + 1) - 1;
        acc[n_acc].addr  = a;
        acc[n_acc].we    = we;
        acc[n_acc].wdata = wd;
        acc[n_acc].rdata = we ? 16'($urandom) : mem_rd(a);
        acc[n_acc].ack   = (w >= 0);
        n_acc++;
    endtask

    task automatic build(input int c, input logic [1:0] o, input logic [15:0] a,
                         input logic [15:0] wd, input int w0, input int w1);
        logic [15:0] p;
        int          s;
        n_acc    = 0;
        t_abort  = 0;
        t_c      = c;
        t_load   = !o[0];
        t_active = 1;
        p        = a;
        s        = c + 1;
        if (o[1]) begin
            add_acc(s, a, 1'b0, wd, w0);
            p       = acc[0].rdata;
            t_abort = !acc[0].ack;
            s       = acc[0].e + 1;
        end
        if (!t_abort) begin
            add_acc(s, p, o[0], wd, o[1] ? w1 : w0);
            t_abort = !acc[n_acc-1].ack;
        end
        t_r = acc[n_acc-1].e + 1;
    endtask

    task automatic compare(input int n);
        bit          er;
        bit          ewe;
        logic [15:0] ea;
        logic [15:0] ewd;
        bit          ebusy;
        bit          edone;
        er = 0; ewe = 0; ea = '0; ewd = '0;
        if (t_active) begin
            for (int k = 0; k < n_acc; k++) begin
                if (n >= acc[k].s && n <= acc[k].e) begin
                    er  = 1;
                    ewe = acc[k].we;
                    ea  = acc[k].addr;
                    ewd = acc[k].wdata;
                end
            end
        end
        ebusy = t_active && (n > t_c) && (n <= t_r);
        edone = t_active && (n == t_r);
        check("busy", busy, ebusy);
        check("done", done, edone);
        check("writeback", enable_writeback, edone && t_load && !t_abort);
        check("mem_req", mem_req, er);
        check("memout", memout, exp_memout);
        check("timeout_err", timeout_err, exp_terr);
        if (er) begin
            check("mem_we", mem_we, ewe);
            check("mem_addr", mem_addr, ea);
            if (ewe) check("mem_wdata", mem_wdata, ewd);
        end
        if (done === 1'b1) begin
            n_dones++;
            last_done    = n;
            done_seen    = 1;
            terr_at_done = timeout_err;
        end
        if (enable_writeback === 1'b1) wb_seen = 1;
        if (mem_req === 1'b1) begin
            if (req_cycles == 0) begin
                first_req_addr = mem_addr;
                first_req_we   = mem_we;
            end
            req_cycles++;
            if (mem_we === 1'b1) begin
                wr_addr = mem_addr;
                wr_data = mem_wdata;
            end
        end
    endtask

    always @(negedge clk) compare(cyc);

    // Drives one cycle of inputs and plays the memory side from the model schedule.
    task automatic tick(input bit st, input logic [1:0] o, input logic [15:0] a, input logic [15:0] wd);
        int n;
        bit accepted;
        int w0;
        int w1;
        bit hit;
        @(negedge clk);
        #1;
        n     = cyc;
        start = st;
        op    = o;
        addr  = a;
        wdata = wd;
        accepted = st && !rst && (!t_active || n > t_r);
        if (accepted) begin
            if (force_w) begin
                w0 = fw0;
                w1 = fw1;
            end else begin
                w0 = $urandom_range(0, 3);
                w1 = $urandom_range(0, 3);
            end
            build(n, o, a, wd, w0, w1);
            n_accepts++;
            last_c   = n;
            exp_terr = 0;
        end
        hit       = 0;
        mem_ack   = 1'b0;
        mem_rdata = 16'($urandom);
        if (t_active) begin
            for (int k = 0; k < n_acc; k++) begin
                if (n >= acc[k].s && n <= acc[k].e) begin
                    hit = 1;
                    if (n == acc[k].e && acc[k].ack) begin
                        mem_ack   = 1'b1;
                        mem_rdata = acc[k].rdata;
                        if (acc[k].we) model_mem[int'(acc[k].addr)] = acc[k].wdata;
                        else if (k == n_acc - 1 && t_load) exp_memout = acc[k].rdata;
                    end
                end
            end
        end
        if (!hit) mem_ack = 1'($urandom_range(0, 1));
        if (t_active && t_abort && n == t_r - 1) exp_terr = 1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] wd,
                         input int w0, input int w1);
        force_w    = 1;
        fw0        = w0;
        fw1        = w1;
        done_seen  = 0;
        wb_seen    = 0;
        req_cycles = 0;
        tick(1'b1, o, a, wd);
        force_w = 0;
    endtask

    task automatic wait_done(input string name);
        int i;
        i = 0;
        while (!done_seen && i < 100) begin
            tick(1'b0, 2'd0, 16'h0, 16'h0);
            i++;
        end
        check(name, done_seen, 1);
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (t_active && cyc <= t_r + 1 && i < 50) begin
            tick(1'b0, 2'd0, 16'h0, 16'h0);
            i++;
        end
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        op        = 2'd0;
        addr      = '0;
        wdata     = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        #2 rst = 1'b1;
        tick(1'b0, 2'd0, 16'h0, 16'h0);
        tick(1'b0, 2'd0, 16'h0, 16'h0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wb", enable_writeback, 0);
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_memout", memout, 0);
        check("rst_terr", timeout_err, 0);
        rst = 1'b0;
        tick(1'b0, 2'd0, 16'h0, 16'h0);

        // LD zero-wait
        model_mem[32'h3000] = 16'h1234;
        issue(2'd0, 16'h3000, 16'h0, 0, 0);
        wait_done("ld_done_seen");
        check("ld_latency", last_done - last_c, 2);
        check("ld_req_cycles", req_cycles, 1);
        check("ld_addr", first_req_addr, 16'h3000);
        check("ld_we", first_req_we, 0);
        check("ld_wb", wb_seen, 1);
        check("ld_memout", memout, 16'h1234);

        // STI through pointer, taken in the cycle right after RESP
        model_mem[32'h4000] = 16'h5000;
        issue(2'd3, 16'h4000, 16'hBEEF, 0, 0);
        wait_done("sti_done_seen");
        check("sti_latency", last_done - last_c, 3);
        check("sti_req_cycles", req_cycles, 2);
        check("sti_ptr_addr", first_req_addr, 16'h4000);
        check("sti_ptr_we", first_req_we, 0);
        check("sti_wr_addr", wr_addr, 16'h5000);
        check("sti_wr_data", wr_data, 16'hBEEF);
        check("sti_wb", wb_seen, 0);
        check("sti_memout", memout, 16'h1234);

        // LDI with 3 wait states on each access
        model_mem[32'h6000] = 16'h7000;
        model_mem[32'h7000] = 16'hCAFE;
        issue(2'd2, 16'h6000, 16'h0, 3, 3);
        wait_done("ldi_done_seen");
        check("ldi_latency", last_done - last_c, 9);
        check("ldi_req_cycles", req_cycles, 8);
        check("ldi_wb", wb_seen, 1);
        check("ldi_memout", memout, 16'hCAFE);

        // Reset while ACC is waiting on the memory
        issue(2'd0, 16'h0005, 16'h0, 5, 0);
        tick(1'b0, 2'd0, 16'h0, 16'h0);
        tick(1'b0, 2'd0, 16'h0, 16'h0);
        tick(1'b0, 2'd0, 16'h0, 16'h0);
        check("pre_rst_req", mem_req, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_memout", memout, 0);
        if (t_active && cyc <= t_r) n_accepts--;
        t_active   = 0;
        exp_memout = '0;
        exp_terr   = 0;
        mem_ack    = 1'b0;
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) tick(1'b0, 2'd0, 16'h0, 16'h0);
        check("rst_no_done", done_seen, 0);
        issue(2'd0, 16'h3000, 16'h0, 0, 0);
        wait_done("post_rst_done_seen");
        check("post_rst_latency", last_done - last_c, 2);
        check("post_rst_memout", memout, 16'h1234);

        // start held high: ignored while busy and in RESP
        for (int i = 0; i < 60; i++)
            tick(1'b1, 2'($urandom_range(0, 3)), 16'($urandom_range(0, 15)), 16'($urandom));

        // random traffic
        for (int i = 0; i < 1500; i++)
            tick($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
                 16'($urandom_range(0, 15)), 16'($urandom));
        drain();

`ifdef MEMACCESS_TIMEOUT_EN
        issue(2'd0, 16'h3000, 16'h0, -1, 0);
        wait_done("to_done_seen");
        check("to_latency", last_done - last_c, 5);
        check("to_terr", terr_at_done, 1);
        check("to_wb", wb_seen, 0);
        issue(2'd0, 16'h3000, 16'h0, 0, 0);
        wait_done("to_next_done_seen");
        check("to_next_terr", terr_at_done, 0);
        check("to_next_wb", wb_seen, 1);
        drain();
`endif

        tick(1'b0, 2'd0, 16'h0, 16'h0);
        check("done_count", n_dones, n_accepts);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
